param_load_counter: RTL and testbench
=====================================

Name: param_load_counter

Overview:
- Parametrised successor to the team's 8-bit loadable counter/register.
- Adds: configurable width, a runtime modulus limit, up/down direction, wrap or saturate mode, count enable, a terminal-count pulse, a sticky overflow flag and a zero flag.
- Sits in the dlab timer/register library.
- Intended as the common counter primitive for prescalers, event counters and down-timers.

Parameters:
- WIDTH, 8, bit width of count, load and lim.
- RESET_VAL, 0, value of count after reset; must be <= 2^WIDTH-1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- set_n  input  1  synchronous active-low load strobe.
- load  input  WIDTH  value loaded when set_n=0.
- en  input  1  count enable, active high.
- up_dn  input  1  1 = count up, 0 = count down.
- sat  input  1  1 = saturate at boundary, 0 = wrap.
- lim  input  WIDTH  modulus limit (top value); count range is 0..lim.
- clr_ovf  input  1  synchronous clear of ovf.
- count  output  WIDTH  registered counter value.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky overflow/underflow flag (wrap mode only).
- zero  output  1  combinational, 1 when count==0.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - count=RESET_VAL, tc=0, ovf=0.
  - zero reflects (RESET_VAL==0).
  - All other inputs are ignored while reset is low.
  - Reset asserted mid-count aborts the count with no tc.
- Priority per rising edge: reset > load (set_n=0) > count (en=1) > hold.
- Load (set_n=0):
  - count <= min(load, lim).
  - tc <= 0.
  - ovf unaffected except by clr_ovf.
  - en is ignored that cycle.
- Hold (set_n=1, en=0): count unchanged, tc <= 0.
- Boundary condition B: (up_dn=1 and count>=lim) or (up_dn=0 and count==0).
- Count (set_n=1, en=1), not at B:
  - count <= count+1 (up) or count-1 (down).
  - tc <= 0.
- Count at B, wrap mode (sat=0):
  - up: count <= 0; down: count <= lim.
  - tc <= 1; ovf <= 1.
- Count at B, saturate mode (sat=1):
  - count unchanged (pinned at lim or 0).
  - tc <= 1 on every enabled cycle spent at the boundary.
  - ovf unchanged.
- tc is a single-cycle pulse registered on the edge where the boundary event is taken.
- tc is never asserted on load or hold.
- Width and arithmetic:
  - All arithmetic is modulo 2^WIDTH.
  - Using count>=lim in up mode means that if lim is lowered below the current count, the next up step is treated as boundary: wrap to 0, or saturate. In saturate mode this clamps count to lim.
  - lim=0: count stays 0; every enabled cycle is a boundary event.
- lim, up_dn and sat may change on any cycle; they take effect on the next edge, with no pipeline.
- ovf:
  - clr_ovf=1 clears ovf on the next edge.
  - If a wrap event and clr_ovf coincide, the set wins and ovf=1.
- zero is derived combinationally from the count register only, with no input-to-output paths.

Test Plan:
1. Reset: WIDTH=8, up, wrap, lim=255, run from 0 for 5 cycles, then pull reset_n low between edges -> count=0 immediately (before the next edge), tc=0, ovf=0, zero=1; release, no change until en.
2. Load and hold: en=0, set_n=0 for one cycle with load=58 -> count=58 after that edge, holds 58 for 5 cycles; set_n=0 with load=32 -> count=32; tc stays 0 throughout.
3. Up wrap: lim=255, sat=0, load 250, en=1 -> 251,252,253,254,255,0,1; tc=1 only in the cycle after the 255->0 edge; ovf=1 and stays 1; clr_ovf one cycle -> ovf=0.
4. Down wrap with modulus: lim=9, up_dn=0, load 2, en=1 -> 1,0,9,8,7; single tc pulse at the 0->9 step; zero=1 only while count=0.
5. Saturate: lim=100, sat=1, up, load 98, en=1 for 5 cycles -> 99,100,100,100,100; tc=1 on each of the three pinned cycles; ovf stays 0; switch up_dn=0 -> 99,98.
6. Priority and clamping:
   - set_n=0 with en=1, load=200, lim=100 -> count=100 (load wins, clamped).
   - Lower lim to 50 while count=100, up, wrap -> next edge count=0, tc=1.
   - clr_ovf=1 on that same edge -> ovf=1.

Source files
------------

// File: rtl/param_load_counter.sv
// Parametrised loadable up/down counter with runtime modulus, wrap/saturate
// modes, terminal-count pulse, sticky overflow flag and zero flag.
module param_load_counter #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic [WIDTH-1:0] load,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic [WIDTH-1:0] lim,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_at_bound;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc;
  logic             w_next_ovf;

  // Up mode uses >= so that lowering lim below the current count is treated
  // as a boundary on the very next enabled step.
  assign w_at_bound     = up_dn ? (r_count >= lim) : (r_count == '0);
  assign w_load_clamped = (load > lim) ? lim : load;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    w_next_ovf   = r_ovf & ~clr_ovf;

    if (!set_n) begin
      w_next_count = w_load_clamped;
    end else if (en) begin
      if (!w_at_bound) begin
        w_next_count = up_dn ? (r_count + 1'b1) : (r_count - 1'b1);
      end else if (sat) begin
        // Pinning to lim (not holding) also clamps a count stranded above lim.
        w_next_count = up_dn ? lim : '0;
        w_next_tc    = 1'b1;
      end else begin
        w_next_count = up_dn ? '0 : lim;
        w_next_tc    = 1'b1;
        w_next_ovf   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RESET_VAL;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
      r_ovf   <= w_next_ovf;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign zero  = (r_count == '0);

endmodule

// File: tb/tb_param_load_counter.sv
// Directed bench for param_load_counter: expected outputs are queued when
// stimulus is applied and compared one cycle later, after the clock edge.
module tb_param_load_counter;

  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             reset_n;
  logic             set_n;
  logic [WIDTH-1:0] load;
  logic             en;
  logic             up_dn;
  logic             sat;
  logic [WIDTH-1:0] lim;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             zero;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  param_load_counter #(.WIDTH(WIDTH), .RESET_VAL(8'd0)) dut (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .set_n   (set_n),
    .load    (load),
    .en      (en),
    .up_dn   (up_dn),
    .sat     (sat),
    .lim     (lim),
    .clr_ovf (clr_ovf),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf),
    .zero    (zero)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Queue the expectation, take one edge, then pop and compare off the edge.
  task automatic cyc(input logic [WIDTH-1:0] e_count, input logic e_tc,
                     input logic e_ovf, input string tag);
    exp_t e;
    sb.push_back('{count: e_count, tc: e_tc, ovf: e_ovf, tag: tag});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".count"}, 32'(count), 32'(e.count));
    chk({e.tag, ".tc"},    32'(tc),    32'(e.tc));
    chk({e.tag, ".ovf"},   32'(ovf),   32'(e.ovf));
    chk({e.tag, ".zero"},  32'(zero),  32'(e.count == '0));
    @(negedge clk_i);
  endtask

  initial begin
    reset_n = 1'b0; set_n = 1'b1; load = '0; en = 1'b0;
    up_dn = 1'b1; sat = 1'b0; lim = 8'd255; clr_ovf = 1'b0;
    #12;
    chk("por.count", 32'(count), 32'd0);
    chk("por.zero",  32'(zero),  32'd1);
    reset_n = 1'b1;
    @(negedge clk_i);

    // 1. Count from 0, then abort with an asynchronous reset between edges.
    en = 1'b1;
    for (int i = 1; i <= 5; i++) cyc(8'(i), 1'b0, 1'b0, "run");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.tc",    32'(tc),    32'd0);
    chk("rst.ovf",   32'(ovf),   32'd0);
    chk("rst.zero",  32'(zero),  32'd1);
    @(negedge clk_i);
    reset_n = 1'b1; en = 1'b0;
    cyc(8'd0, 1'b0, 1'b0, "rst_rel");

    // 2. Load and hold.
    set_n = 1'b0; load = 8'd58;
    cyc(8'd58, 1'b0, 1'b0, "load58");
    set_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(8'd58, 1'b0, 1'b0, "hold58");
    set_n = 1'b0; load = 8'd32;
    cyc(8'd32, 1'b0, 1'b0, "load32");

    // 3. Up wrap at 255, sticky ovf, then clear.
    load = 8'd250; en = 1'b1;
    cyc(8'd250, 1'b0, 1'b0, "load250");
    set_n = 1'b1;
    for (int i = 251; i <= 255; i++) cyc(8'(i), 1'b0, 1'b0, "up");
    cyc(8'd0, 1'b1, 1'b1, "upwrap");
    cyc(8'd1, 1'b0, 1'b1, "upafter");
    clr_ovf = 1'b1;
    cyc(8'd2, 1'b0, 1'b0, "clrovf");
    clr_ovf = 1'b0; en = 1'b0;

    // 4. Down wrap with modulus 9.
    lim = 8'd9; up_dn = 1'b0; set_n = 1'b0; load = 8'd2;
    cyc(8'd2, 1'b0, 1'b0, "load2");
    set_n = 1'b1; en = 1'b1;
    cyc(8'd1, 1'b0, 1'b0, "dn1");
    cyc(8'd0, 1'b0, 1'b0, "dn0");
    cyc(8'd9, 1'b1, 1'b1, "dnwrap");
    cyc(8'd8, 1'b0, 1'b1, "dn8");
    cyc(8'd7, 1'b0, 1'b1, "dn7");
    en = 1'b0; clr_ovf = 1'b1;
    cyc(8'd7, 1'b0, 1'b0, "clr2");
    clr_ovf = 1'b0;

    // 5. Saturate at 100, then reverse.
    lim = 8'd100; sat = 1'b1; up_dn = 1'b1; set_n = 1'b0; load = 8'd98;
    cyc(8'd98, 1'b0, 1'b0, "load98");
    set_n = 1'b1; en = 1'b1;
    cyc(8'd99,  1'b0, 1'b0, "sat99");
    cyc(8'd100, 1'b0, 1'b0, "sat100");
    for (int i = 0; i < 3; i++) cyc(8'd100, 1'b1, 1'b0, "satpin");
    up_dn = 1'b0;
    cyc(8'd99, 1'b0, 1'b0, "satdn99");
    cyc(8'd98, 1'b0, 1'b0, "satdn98");

    // 6. Load beats enable and is clamped; lowered lim wraps; set beats clear.
    sat = 1'b0; up_dn = 1'b1; set_n = 1'b0; load = 8'd200;
    cyc(8'd100, 1'b0, 1'b0, "ldclamp");
    set_n = 1'b1; lim = 8'd50; clr_ovf = 1'b1;
    cyc(8'd0, 1'b1, 1'b1, "limdrop");
    clr_ovf = 1'b0; en = 1'b0;
    cyc(8'd0, 1'b0, 1'b1, "holdovf");

    // lim=0: every enabled cycle is a boundary event; saturated down at 0.
    lim = 8'd0; en = 1'b1;
    cyc(8'd0, 1'b1, 1'b1, "lim0a");
    cyc(8'd0, 1'b1, 1'b1, "lim0b");
    clr_ovf = 1'b1; sat = 1'b1; up_dn = 1'b0; lim = 8'd20;
    cyc(8'd0, 1'b1, 1'b0, "satdn0");
    clr_ovf = 1'b0; en = 1'b0;
    cyc(8'd0, 1'b0, 1'b0, "hold0");

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
